fetch_queue: RTL

Circular FIFO directly downstream of the program-counter/instruction-fetch stage. Buffers fetched {pc, instruction} pairs until decode/issue dequeues them. Drives queue_full back to the PC stage, which holds the PC while it is asserted. A flush empties the buffer on a redirect, such as a branch mispredict.

---
 rtl/fetch_queue_pkg.sv | 27 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_mem.sv | 33 +++
 rtl/fetch_queue.sv | 107 ++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and sizing for the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FQ_XLEN  = 32;
    localparam int FQ_DEPTH = 8;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [FQ_XLEN-1:0] pc,
                                                input logic [FQ_XLEN-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-side enqueue and decode-side dequeue handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            queue_full;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  queue_full, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output queue_full, out_valid, out_pc, out_instr
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_mem
// Description : DEPTH x WIDTH register array, one write port, async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = 2 * FQ_XLEN
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    // Storage is intentionally left unreset; validity is tracked by the occupancy count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular {pc, instr} FIFO between fetch and decode with flush,
//               full-margin back-pressure and sticky overflow flag.
//               Define FETCHQ_BYPASS_EN for same-cycle empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH       = FQ_DEPTH,
    parameter int FULL_MARGIN = 1,
    parameter int XLEN        = FQ_XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    fetch_queue_if.slave           fq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_full_level = CNT_W'(DEPTH - FULL_MARGIN);

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_mem_valid;
    logic              w_has_room;
    logic              w_deq;
    logic              w_enq;
    logic              w_drop;
    logic              w_write;
    logic [2*XLEN-1:0] w_rd_data;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_write),
        .wr_addr (r_wr_ptr),
        .wr_data ({fq.in_pc, fq.in_instr}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_mem_valid  = (r_count != '0);
        fq.out_valid = w_mem_valid;
        fq.out_pc    = w_rd_data[2*XLEN-1:XLEN];
        fq.out_instr = w_rd_data[XLEN-1:0];
        w_deq        = w_mem_valid && fq.out_ready;
        // A dequeue in the same cycle frees the slot a full queue would otherwise refuse.
        w_has_room   = (r_count < c_depth) || w_deq;
        w_enq        = fq.in_valid && w_has_room;
        w_drop       = fq.in_valid && !w_has_room;
`ifdef FETCHQ_BYPASS_EN
        if (!w_mem_valid && fq.in_valid && !flush) begin
            fq.out_valid = 1'b1;
            fq.out_pc    = fq.in_pc;
            fq.out_instr = fq.in_instr;
            // Consumed straight off the input: nothing is stored.
            if (fq.out_ready) begin
                w_enq = 1'b0;
            end
        end
`endif
        w_write = w_enq && !flush && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fq.queue_full = (r_count >= c_full_level);
    assign count         = r_count;
    assign overflow_err  = r_overflow;

endmodule
`default_nettype wire
